addsub_entry: RTL and testbench



---
 rtl/addsub_entry_pkg.sv | 26 ++
 rtl/addsub_entry_core.sv | 26 ++
 rtl/addsub_entry.sv | 124 ++++++++++++
 tb/tb_addsub_entry.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/addsub_entry_pkg.sv
// Shared types for the front-panel operand entry / add-subtract unit:
// entry FSM states, opcode encodings and the opcode-dependent flag select.
package addsub_entry_pkg;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    SHOW    = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADDU = 2'b00;
  localparam logic [1:0] OP_SUBS = 2'b01;
  localparam logic [1:0] OP_ADDS = 2'b10;
  localparam logic [1:0] OP_SUBU = 2'b11;

  // Signed ops report overflow; unsigned subtract reports borrow as inverted carry.
  function automatic logic selFlag(input logic [1:0] op, input logic cout, input logic cmsb);
    case (op)
      OP_ADDU: return cout;
      OP_SUBU: return ~cout;
      default: return cout ^ cmsb;
    endcase
  endfunction

endpackage

// File: rtl/addsub_entry_core.sv
// Combinational WIDTH-bit adder/subtractor (A + ~B + 1 when subtracting),
// exposing carry out and carry into the MSB for flag generation.
module addsub_core
  import addsub_entry_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_full;

  assign w_b_eff = i_b ^ {WIDTH{i_sub}};
  assign w_full  = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_sub};
  assign o_sum   = w_full[WIDTH-1:0];
  assign o_cout  = w_full[WIDTH];
  // The MSB sum bit is a ^ b ^ carry-in, so the carry into the MSB falls out directly.
  assign o_cmsb  = w_full[WIDTH-1] ^ i_a[WIDTH-1] ^ w_b_eff[WIDTH-1];

endmodule

// File: rtl/addsub_entry.sv
// Front-panel operand entry FSM plus registered add/subtract result.
// Optional macro ADDSUB_ACCUM_EN: a commit click in SHOW loads A from the result.
module addsub_entry
  import addsub_entry_pkg::*;
#(
  parameter  int WIDTH   = 7,
  parameter  int SLIDE_W = 4,
  localparam int NCH     = (WIDTH + SLIDE_W - 1) / SLIDE_W,
  localparam int STEP_W  = $clog2(2 * NCH + 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rot_event,
  input  logic              rot_dir,
  input  logic [SLIDE_W-1:0] slide,
  output logic [WIDTH-1:0]  sum,
  output logic              flag,
  output logic              valid,
  output logic [STEP_W-1:0] step
);

  state_t            r_state, w_state_nx;
  logic [STEP_W-1:0] r_step, w_step_nx;
  logic [WIDTH-1:0]  r_a, r_b, w_a_nx, w_b_nx;
  logic [1:0]        r_op, w_op_nx;
  logic              r_prev;
  logic [WIDTH-1:0]  r_sum;
  logic              r_flag;
  logic              w_click;
  int                w_idx;
  logic [WIDTH-1:0]  w_core_sum;
  logic              w_cout, w_cmsb;

  assign w_click = rot_event & ~r_prev;

  always_comb begin
    w_state_nx = r_state;
    w_step_nx  = r_step;
    w_a_nx     = r_a;
    w_b_nx     = r_b;
    w_op_nx    = r_op;
    w_idx      = 0;
    if (w_click) begin
      if (rot_dir) begin
        w_state_nx = LOAD_A;
        w_step_nx  = '0;
      end else begin
        case (r_state)
          LOAD_A: begin
            w_idx = int'(r_step);
            for (int i = 0; i < WIDTH; i++)
              if (i / SLIDE_W == w_idx) w_a_nx[i] = slide[i % SLIDE_W];
            w_step_nx = r_step + STEP_W'(1);
            if (r_step == STEP_W'(NCH - 1)) w_state_nx = LOAD_B;
          end
          LOAD_B: begin
            w_idx = int'(r_step) - NCH;
            for (int i = 0; i < WIDTH; i++)
              if (i / SLIDE_W == w_idx) w_b_nx[i] = slide[i % SLIDE_W];
            w_step_nx = r_step + STEP_W'(1);
            if (r_step == STEP_W'(2 * NCH - 1)) w_state_nx = LOAD_OP;
          end
          LOAD_OP: begin
            w_op_nx    = slide[1:0];
            w_state_nx = SHOW;
            w_step_nx  = STEP_W'(2 * NCH + 1);
          end
          SHOW: begin
`ifdef ADDSUB_ACCUM_EN
            w_a_nx     = r_sum;
            w_state_nx = LOAD_B;
            w_step_nx  = STEP_W'(NCH);
`else
            w_state_nx = LOAD_A;
            w_step_nx  = '0;
`endif
          end
          default: begin
            w_state_nx = LOAD_A;
            w_step_nx  = '0;
          end
        endcase
      end
    end
  end

  // Edge history resets high so a level already present at reset release is not a click.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOAD_A;
      r_step  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_ADDU;
      r_prev  <= 1'b1;
      r_sum   <= '0;
      r_flag  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_step  <= w_step_nx;
      r_a     <= w_a_nx;
      r_b     <= w_b_nx;
      r_op    <= w_op_nx;
      r_prev  <= rot_event;
      r_sum   <= w_core_sum;
      r_flag  <= selFlag(r_op, w_cout, w_cmsb);
    end
  end

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .i_a    (r_a),
    .i_b    (r_b),
    .i_sub  (r_op[0]),
    .o_sum  (w_core_sum),
    .o_cout (w_cout),
    .o_cmsb (w_cmsb)
  );

  assign sum   = r_sum;
  assign flag  = r_flag;
  assign valid = (r_state == SHOW);
  assign step  = r_step;

endmodule

// File: tb/tb_addsub_entry.sv
// Self-checking bench for addsub_entry (WIDTH=7, SLIDE_W=4): directed table,
// entry corner cases and randomized operations against an arithmetic model.
module tb_addsub_entry;

  localparam int WIDTH   = 7;
  localparam int SLIDE_W = 4;
  localparam int NCH     = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rot_event;
  logic       rot_dir;
  logic [3:0] slide;
  logic [6:0] sum;
  logic       flag;
  logic       valid;
  logic [2:0] step;

  int nChecks = 0;
  int nPass   = 0;

  typedef struct {
    int   a;
    int   b;
    int   op;
    int   expSum;
    logic expFlag;
  } vec_t;

  addsub_entry #(.WIDTH(WIDTH), .SLIDE_W(SLIDE_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rot_event (rot_event),
    .rot_dir   (rot_dir),
    .slide     (slide),
    .sum       (sum),
    .flag      (flag),
    .valid     (valid),
    .step      (step)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  // One click: raise on a falling edge, drop after one cycle, idle a cycle.
  // Returns at a falling edge two rising edges after the click edge.
  task automatic applyStimulus(input logic dir, input logic [3:0] data);
    @(negedge clk);
    slide     = data;
    rot_dir   = dir;
    rot_event = 1'b1;
    @(negedge clk);
    rot_event = 1'b0;
    @(negedge clk);
  endtask

  task automatic enterValue(input int v);
    logic [3:0] chunk;
    for (int k = 0; k < NCH; k++) begin
      chunk = 4'((v >> (k * SLIDE_W)) & 15);
      if (k == NCH - 1) chunk[3] = 1'($urandom_range(0, 1));
      applyStimulus(1'b0, chunk);
    end
  endtask

  task automatic runOp(input int a, input int b, input int op);
    logic [3:0] opSlide;
    opSlide = {2'($urandom_range(0, 3)), 2'(op)};
    applyStimulus(1'b1, 4'h0);
    enterValue(a);
    enterValue(b);
    applyStimulus(1'b0, opSlide);
  endtask

  // Reference arithmetic from plain integer math, not bit-level adders.
  function automatic void refCalc(input int a, input int b, input int op,
                                  output int rs, output logic rf);
    int sa, sb, r;
    sa = (a >= 64) ? a - 128 : a;
    sb = (b >= 64) ? b - 128 : b;
    case (op)
      0: begin r = a + b; rs = r % 128; rf = (r >= 128); end
      1: begin r = sa - sb; rs = (a - b + 128) % 128; rf = (r < -64) || (r > 63); end
      2: begin r = sa + sb; rs = (a + b) % 128; rf = (r < -64) || (r > 63); end
      default: begin rs = (a - b + 128) % 128; rf = (a < b); end
    endcase
  endfunction

  initial begin
    vec_t vecs[8];
    int   rs;
    logic rf;
    int   ra, rb, rop;

    vecs[0] = '{a: 'h05, b: 'h03, op: 0, expSum: 'h08, expFlag: 1'b0};
    vecs[1] = '{a: 'h7F, b: 'h01, op: 0, expSum: 'h00, expFlag: 1'b1};
    vecs[2] = '{a: 'h01, b: 'h02, op: 3, expSum: 'h7F, expFlag: 1'b1};
    vecs[3] = '{a: 'h3F, b: 'h7F, op: 1, expSum: 'h40, expFlag: 1'b1};
    vecs[4] = '{a: 'h3F, b: 'h01, op: 2, expSum: 'h40, expFlag: 1'b1};
    vecs[5] = '{a: 'h40, b: 'h40, op: 2, expSum: 'h00, expFlag: 1'b1};
    vecs[6] = '{a: 'h10, b: 'h10, op: 1, expSum: 'h00, expFlag: 1'b0};
    vecs[7] = '{a: 'h50, b: 'h20, op: 3, expSum: 'h30, expFlag: 1'b0};

    // Reset with rot_event already high: release must not count as a click.
    rst_n     = 1'b0;
    rot_event = 1'b1;
    rot_dir   = 1'b0;
    slide     = 4'h9;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("noClickAtReset", 32'(step), 32'd0);
    rot_event = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("resetStep", 32'(step), 32'd0);
    checkOutput("resetValid", 32'(valid), 32'd0);
    checkOutput("resetSum", 32'(sum), 32'd0);
    checkOutput("resetFlag", 32'(flag), 32'd0);

    // A chunk 0, then restart: A keeps its low bits, visible through sum (op add, B=0).
    applyStimulus(1'b0, 4'h5);
    checkOutput("chunk0Step", 32'(step), 32'd1);
    checkOutput("chunk0Sum", 32'(sum), 32'h05);
    applyStimulus(1'b1, 4'h0);
    checkOutput("ccwStep", 32'(step), 32'd0);
    checkOutput("ccwValid", 32'(valid), 32'd0);
    checkOutput("ccwSumRetained", 32'(sum), 32'h05);

    // A held level is a single click.
    @(negedge clk);
    slide     = 4'h2;
    rot_dir   = 1'b0;
    rot_event = 1'b1;
    repeat (10) @(negedge clk);
    rot_event = 1'b0;
    @(negedge clk);
    checkOutput("holdOneStep", 32'(step), 32'd1);

    for (int i = 0; i < 8; i++) begin
      runOp(vecs[i].a, vecs[i].b, vecs[i].op);
      checkOutput($sformatf("vec%0dValid", i), 32'(valid), 32'd1);
      checkOutput($sformatf("vec%0dStep", i), 32'(step), 32'd5);
      checkOutput($sformatf("vec%0dSum", i), 32'(sum), 32'(vecs[i].expSum));
      checkOutput($sformatf("vec%0dFlag", i), 32'(flag), 32'(vecs[i].expFlag));
    end

    // Commit click while showing a result.
    runOp('h05, 'h03, 0);
    checkOutput("showSum", 32'(sum), 32'h08);
    applyStimulus(1'b0, 4'h0);
`ifdef ADDSUB_ACCUM_EN
    checkOutput("accumStep", 32'(step), 32'd2);
    checkOutput("accumValid", 32'(valid), 32'd0);
    enterValue('h02);
    applyStimulus(1'b0, 4'h0);
    checkOutput("accumValid2", 32'(valid), 32'd1);
    checkOutput("accumSum", 32'(sum), 32'h0A);
`else
    checkOutput("showCwStep", 32'(step), 32'd0);
    checkOutput("showCwValid", 32'(valid), 32'd0);
    checkOutput("showCwSum", 32'(sum), 32'h08);
`endif

    for (int i = 0; i < 40; i++) begin
      ra  = int'($urandom_range(0, 127));
      rb  = int'($urandom_range(0, 127));
      rop = int'($urandom_range(0, 3));
      refCalc(ra, rb, rop, rs, rf);
      runOp(ra, rb, rop);
      checkOutput($sformatf("rnd%0dValid", i), 32'(valid), 32'd1);
      checkOutput($sformatf("rnd%0dSum a=%0h b=%0h op=%0d", i, ra, rb, rop), 32'(sum), 32'(rs));
      checkOutput($sformatf("rnd%0dFlag a=%0h b=%0h op=%0d", i, ra, rb, rop), 32'(flag), 32'(rf));
    end

    // Asynchronous reset in the middle of B entry.
    applyStimulus(1'b1, 4'h0);
    enterValue('h25);
    applyStimulus(1'b0, 4'h1);
    checkOutput("midBStep", 32'(step), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstStep", 32'(step), 32'd0);
    checkOutput("asyncRstSum", 32'(sum), 32'd0);
    checkOutput("asyncRstFlag", 32'(flag), 32'd0);
    checkOutput("asyncRstValid", 32'(valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("postRstSum", 32'(sum), 32'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
